// File: rtl/jedro_1_dmem_arb.sv
// jedro_1_dmem_arb: shares the jedro-1 data-RAM port between LSU (r0) and a secondary master (r1); JEDRO_1_ARB_RR_EN selects round-robin, else r0 has fixed priority
module jedro_1_dmem_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    r0_req_i,
  input  logic [DATA_WIDTH/8-1:0] r0_we_i,
  input  logic [DATA_WIDTH-1:0]   r0_addr_i,
  input  logic [DATA_WIDTH-1:0]   r0_wdata_i,
  output logic                    r0_gnt_o,
  output logic                    r0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   r0_rdata_o,
  input  logic                    r1_req_i,
  input  logic [DATA_WIDTH/8-1:0] r1_we_i,
  input  logic [DATA_WIDTH-1:0]   r1_addr_i,
  input  logic [DATA_WIDTH-1:0]   r1_wdata_i,
  output logic                    r1_gnt_o,
  output logic                    r1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   r1_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int BW    = DATA_WIDTH / 8;
  localparam int DEPTH = READ_LATENCY + 1;

  logic                  acc, rd_acc, ret, ret_id;
  logic [BW-1:0]         sel_we;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata;
  logic [DEPTH-1:0]      v_q, id_q;

`ifdef JEDRO_1_ARB_RR_EN
  logic last_q;
  always_comb begin
    r0_gnt_o = rstn_i & r0_req_i & (~r1_req_i | last_q);
    r1_gnt_o = rstn_i & r1_req_i & (~r0_req_i | ~last_q);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) last_q <= 1'b1;
    else if (acc) last_q <= r1_gnt_o;
  end
`else
  always_comb begin
    r0_gnt_o = rstn_i & r0_req_i;
    r1_gnt_o = rstn_i & r1_req_i & ~r0_req_i;
  end
`endif

  always_comb begin
    acc       = r0_gnt_o | r1_gnt_o;
    sel_we    = r1_gnt_o ? r1_we_i : r0_we_i;
    sel_addr  = r1_gnt_o ? r1_addr_i : r0_addr_i;
    sel_wdata = r1_gnt_o ? r1_wdata_i : r0_wdata_i;
    rd_acc    = acc & ~|sel_we;
    ret       = v_q[DEPTH-1];
    ret_id    = id_q[DEPTH-1];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      v_q         <= '0;
      id_q        <= '0;
      r0_rvalid_o <= 1'b0;
      r1_rvalid_o <= 1'b0;
      r0_rdata_o  <= '0;
      r1_rdata_o  <= '0;
    end else begin
      mem_en_o    <= acc;
      mem_we_o    <= acc ? sel_we : '0;
      if (acc) begin
        mem_addr_o  <= sel_addr;
        mem_wdata_o <= sel_wdata;
      end
      // tag slots track every cycle so the return lines up with RAM latency
      v_q         <= {v_q[DEPTH-2:0], rd_acc};
      id_q        <= {id_q[DEPTH-2:0], r1_gnt_o};
      r0_rvalid_o <= ret & ~ret_id;
      r1_rvalid_o <= ret & ret_id;
      if (ret & ~ret_id) r0_rdata_o <= mem_rdata_i;
      if (ret & ret_id) r1_rdata_o <= mem_rdata_i;
    end
  end
endmodule
